// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter with round-robin grant, lock/timeout,
// and one-cycle read-data return routing.
module data_mem_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          lock0,
  input  logic [3:0]    we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          lock1,
  input  logic [3:0]    we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_err
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rsel_q, rpend_q;
  logic       tmo;

  // Timeout fires on the last permitted locked cycle.
  assign tmo = (state_q != IDLE) &&
               (cnt_q == 8'(LOCK_MAX - 1));

  // Grant: owner only while locked, round-robin when idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      gnt0 = req0 &
             ((state_q == OWN0) ||
              ((state_q == IDLE) && (!req1 || last_q)));
      gnt1 = req1 &
             ((state_q == OWN1) ||
              ((state_q == IDLE) && (!req0 || !last_q)));
    end
  end

  // Memory-side mux from the granted requester.
  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      gnt1: begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

  assign mem_en   = gnt0 | gnt1;
  assign lock_err = reset & tmo;

  // Ownership FSM, lock counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt0 && lock0)      state_d = OWN0;
        else if (gnt1 && lock1) state_d = OWN1;
      end
      OWN0: begin
        cnt_d = cnt_q + 8'd1;
        if (tmo) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (gnt0 && !lock0) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        cnt_d = cnt_q + 8'd1;
        if (tmo) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (gnt1 && !lock1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Remember who issued a read so the data returns to them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsel_q  <= 1'b0;
      rpend_q <= 1'b0;
    end else begin
      rsel_q  <= gnt1;
      rpend_q <= mem_en && (mem_we == 4'b0000);
    end
  end

  assign rvalid0 = rpend_q & ~rsel_q;
  assign rvalid1 = rpend_q &  rsel_q;
  assign rdata0  = (reset && !rsel_q) ? mem_rdata : '0;
  assign rdata1  = (reset &&  rsel_q) ? mem_rdata : '0;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port (DataMem and VGATextCard bank behind MemDecoder) between two requesters.
  - Requester 0: the CPU load/store path.
  - Requester 1: a secondary master, either the program loader/DMA or the debug port.
- Per-cycle round-robin grant, an optional lock for atomic read-modify-write sequences, a lock-timeout guard, and one-cycle read-data return routing.
- Sits between the requesters and the memory decode/encode path; the memory side behaves like DataMem (byte-enable writes, registered read data).

Parameters:
- AW, 11, word address width (memAddr[12:2]).
- DW, 32, data width.
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (2..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req0  input  1  requester 0 access request, held until granted.
- lock0  input  1  requester 0 asks to keep ownership after this grant.
- we0  input  4  requester 0 byte write enables; 0000 = read.
- addr0  input  AW  requester 0 word address.
- wdata0  input  DW  requester 0 write data.
- gnt0  output  1  requester 0 access accepted this cycle.
- rvalid0  output  1  read data for requester 0 valid.
- rdata0  output  DW  read data to requester 0.
- req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the requester 0 ports, for requester 1.
- mem_en  output  1  memory enable.
- mem_we  output  4  byte write enables to memory.
- mem_addr  output  AW  memory word address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid the cycle after a read enable.
- lock_err  output  1  one-cycle pulse on lock timeout.

Behaviour:
- States: IDLE, OWN0, OWN1.
  - IDLE: round-robin between req0 and req1.
  - OWNn: only requester n may be granted. The other requester's req is ignored and it stays ungranted.
- Grant is combinational from req, state and last-grant pointer `last`.
  - gnt0 = req0 & (state==OWN0 | (state==IDLE & (~req1 | last==1))).
  - gnt1 is symmetric.
  - gnt0 and gnt1 are never high together.
- mem_en = gnt0|gnt1. mem_we, mem_addr and mem_wdata are muxed from the granted requester. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- `last` updates to the index of the granted requester every cycle a grant occurs.
- Transitions:
  - IDLE -> OWNn when gntn & lockn.
  - OWNn -> IDLE when a grant occurs with lockn=0, or on lock timeout.
  - OWNn with reqn=0: stay in OWNn and count the cycle. The lock holds across idle cycles.
- Lock counter:
  - Cleared on entry to OWNn and incremented each cycle in OWNn.
  - When the count reaches LOCK_MAX-1: go to IDLE next cycle, pulse lock_err for 1 cycle, and set last=n so the other requester wins next.
  - If a grant is in flight that cycle, it completes.
- Read return:
  - Register rsel (owner index) and rpend (mem_en & mem_we==0) each cycle.
  - Next cycle: rvalid<rsel> = rpend, and rdata<rsel> = mem_rdata.
  - The non-selected rdata output is 0.
  - Read latency is exactly 1 cycle after gnt. Back-to-back reads from alternating requesters are each routed correctly.
- Writes produce no rvalid.
- Simultaneous req0 & req1 in IDLE with last==1 (reset value): requester 0 wins.
- While reset=0:
  - gnt0, gnt1 and mem_en are forced to 0.
  - mem_we, mem_addr and mem_wdata are forced to 0.
  - rvalid0, rvalid1, lock_err, rdata0 and rdata1 are 0.
  - state = IDLE, last = 1, counter = 0.
- Reset mid-lock or mid-read:
  - The pending rvalid is dropped and the lock is released.
  - The first cycle after release behaves as from power-up.

Test Plan:
- Reset release, req0=1 and req1=1 reads to addr 0x010 and 0x020 every cycle -> gnt alternates 0,1,0,1. rvalid0 follows each gnt0 by one cycle with rdata0 = mem_rdata; same for requester 1.
- req1 only, write we1=1111 addr 0x005 wdata 0xDEADBEEF -> gnt1=1, mem_we=1111, mem_addr=0x005, mem_wdata=0xDEADBEEF in the same cycle, no rvalid1.
- req0 with lock0=1 for 3 accesses (read, then sb we0=0010), req1 constant -> gnt1 stays 0 until the grant with lock0=0. gnt1 is high the next cycle.
- LOCK_MAX=4: requester 1 locks then drops req1, req0 high -> lock_err pulses on the 4th locked cycle. gnt0 is high the following cycle.
- Read granted to requester 0, then reset asserted in the return cycle -> rvalid0=0, gnt=0, mem_en=0 during reset. After release, a simultaneous req0/req1 grants requester 0.
- No requests for 10 cycles -> mem_en=0, mem_we=0, rvalid0=rvalid1=0 throughout.
